// File: rtl/identify_sequencer_if.sv
// Fetch, decoder and issue signals of the Identify front-end sequencer.
// Instruction words use Power ISA bit numbering: bit 0 is the MSB.
interface identify_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             fetch_valid;
    logic [0:31]      fetch_instr;
    logic             fetch_ready;
    logic             flush;
    logic             id_en;
    logic [0:31]      id_instr;
    logic             issue_valid;
    logic             issue_ready;
    logic             issue_prefixed;
    logic [0:31]      issue_prefix;
    logic [0:31]      issue_suffix;
    logic             err_prefix;
    logic [CNT_W-1:0] issued_count;

    modport master (
        output fetch_valid, fetch_instr, flush, issue_ready,
        input  fetch_ready, id_en, id_instr, issue_valid, issue_prefixed,
               issue_prefix, issue_suffix, err_prefix, issued_count
    );

    modport slave (
        input  fetch_valid, fetch_instr, flush, issue_ready,
        output fetch_ready, id_en, id_instr, issue_valid, issue_prefixed,
               issue_prefix, issue_suffix, err_prefix, issued_count
    );
endinterface

// File: rtl/identify_sequencer.sv
// Buffers fetch words, drives the Identify decoder and pairs prefixed
// (opcode 1) instructions with their suffix before presenting them to issue.
module identify_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input logic                 i_clk,
    input logic                 i_rst,
    identify_sequencer_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PREFIX,
        S_FULL
    } state_t;

    state_t           state;
    logic [0:31]      mem [FIFO_DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      fill;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [0:31]      head;
    logic             head_is_prefix;
    logic [0:31]      held_prefix;
    logic             prefixed_q;
    logic [0:31]      prefix_q;
    logic [0:31]      suffix_q;
    logic [CNT_W-1:0] count_q;

    assign full           = (fill == (AW+1)'(FIFO_DEPTH));
    assign empty          = (fill == '0);
    assign head           = mem[rd_ptr];
    assign head_is_prefix = (head[0:5] == 6'b000001);

    // Fullness comes from the registered fill level only, so a word is
    // refused while full even if the head is leaving in the same cycle.
    assign bus.fetch_ready = !full && !bus.flush;
    assign push            = bus.fetch_valid && bus.fetch_ready;
    assign pop             = !empty && !bus.flush &&
                             ((state != S_FULL) || bus.issue_ready);

    assign bus.id_en      = pop;
    assign bus.id_instr   = pop ? head : '0;
    assign bus.err_prefix = pop && (state == S_PREFIX) && head_is_prefix;

    assign bus.issue_valid    = (state == S_FULL);
    assign bus.issue_prefixed = prefixed_q;
    assign bus.issue_prefix   = prefix_q;
    assign bus.issue_suffix   = suffix_q;
    assign bus.issued_count   = count_q;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.fetch_instr;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else if (bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fill <= fill + 1'b1;
            end else if (pop && !push) begin
                fill <= fill - 1'b1;
            end
        end
    end

    // Issue outputs keep their last values outside FULL; they only move on
    // a pop that completes an instruction, on flush, or on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_EMPTY;
            held_prefix <= '0;
            prefixed_q  <= 1'b0;
            prefix_q    <= '0;
            suffix_q    <= '0;
            count_q     <= '0;
        end else if (bus.flush) begin
            state       <= S_EMPTY;
            held_prefix <= '0;
            prefixed_q  <= 1'b0;
            prefix_q    <= '0;
            suffix_q    <= '0;
        end else begin
            if ((state == S_FULL) && bus.issue_ready) begin
                count_q <= count_q + 1'b1;
            end
            if (pop) begin
                if (head_is_prefix) begin
                    held_prefix <= head;
                    state       <= S_PREFIX;
                end else if (state == S_PREFIX) begin
                    prefixed_q  <= 1'b1;
                    prefix_q    <= held_prefix;
                    suffix_q    <= head;
                    held_prefix <= '0;
                    state       <= S_FULL;
                end else begin
                    prefixed_q <= 1'b0;
                    prefix_q   <= '0;
                    suffix_q   <= head;
                    state      <= S_FULL;
                end
            end else if ((state == S_FULL) && bus.issue_ready) begin
                state <= S_EMPTY;
            end
        end
    end
endmodule

// File: tb/tb_identify_sequencer.sv
// Self-checking bench for identify_sequencer: vector table, directed corner
// cases, then random traffic against an instruction-stream reference model.
module tb_identify_sequencer;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    identify_sequencer_if #(.CNT_W(CNT_W)) bus ();

    identify_sequencer #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        fv;
        logic [31:0] instr;
        logic        rdy;
        logic        fr;
        logic        en;
        logic [31:0] idi;
        logic        v;
        logic        pf;
        logic [31:0] pfx;
        logic [31:0] sfx;
        logic        err;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic        pf;
        logic [31:0] pfx;
        logic [31:0] sfx;
    } ins_t;

    int          errors = 0;
    int          checks = 0;
    vec_t        tbl [13];
    ins_t        q [$];
    logic        pend_valid;
    logic [31:0] pend_word;
    int          err_exp;
    int          err_seen;
    int          model_cnt;
    logic [31:0] bp_words [5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] snap();
        return {11'b0, bus.fetch_ready, bus.id_en, 32'(bus.id_instr), bus.issue_valid,
                bus.issue_prefixed, 32'(bus.issue_prefix), 32'(bus.issue_suffix),
                bus.err_prefix, 16'(bus.issued_count)};
    endfunction

    function automatic logic [127:0] expect_of(input vec_t t);
        return {11'b0, t.fr, t.en, t.idi, t.v, t.pf, t.pfx, t.sfx, t.err, t.cnt};
    endfunction

    function automatic vec_t mk(input logic fv, input logic [31:0] instr, input logic rdy,
                                input logic fr, input logic en, input logic [31:0] idi,
                                input logic v, input logic pf, input logic [31:0] pfx,
                                input logic [31:0] sfx, input logic err, input logic [15:0] cnt);
        vec_t t;
        t.fv = fv; t.instr = instr; t.rdy = rdy; t.fr = fr; t.en = en; t.idi = idi;
        t.v = v; t.pf = pf; t.pfx = pfx; t.sfx = sfx; t.err = err; t.cnt = cnt;
        return t;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.issue_valid) seen = 1'b1;
            else next_cycle();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: got no issue_valid expected issue_valid within 10 cycles", name);
        end
    endtask

    // Reference model: instructions are formed from the accepted word stream.
    task automatic model_accept(input logic [31:0] w);
        if (w[31:26] == 6'b000001) begin
            if (pend_valid) err_exp++;
            pend_valid = 1'b1;
            pend_word  = w;
        end else if (pend_valid) begin
            q.push_back('{pf: 1'b1, pfx: pend_word, sfx: w});
            pend_valid = 1'b0;
        end else begin
            q.push_back('{pf: 1'b0, pfx: 32'h0, sfx: w});
        end
    endtask

    task automatic sample_and_model();
        ins_t e;
        @(negedge clk);
        if (!bus.id_en) check("rnd_id_instr_idle", 128'(bus.id_instr), 128'(32'h0));
        if (bus.err_prefix) err_seen++;
        if (bus.issue_valid && bus.issue_ready) begin
            model_cnt++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rnd_issue: got %0h expected no instruction", bus.issue_suffix);
            end else begin
                e = q.pop_front();
                check("rnd_issue",
                      128'({bus.issue_prefixed, 32'(bus.issue_prefix), 32'(bus.issue_suffix)}),
                      128'({e.pf, e.pfx, e.sfx}));
            end
        end
        if (bus.fetch_valid && bus.fetch_ready) model_accept(32'(bus.fetch_instr));
        next_cycle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.fetch_valid = 1'b0;
        bus.fetch_instr = '0;
        bus.flush       = 1'b0;
        bus.issue_ready = 1'b0;
        rst             = 1'b1;

        tbl[0]  = mk(1'b1, 32'h7C000378, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 16'd0);
        tbl[1]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h7C000378, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 16'd0);
        tbl[2]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h7C000378, 1'b0, 16'd0);
        tbl[3]  = mk(1'b1, 32'h04000000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h7C000378, 1'b0, 16'd1);
        tbl[4]  = mk(1'b1, 32'h38600005, 1'b1, 1'b1, 1'b1, 32'h04000000, 1'b0, 1'b0, 32'h0,        32'h7C000378, 1'b0, 16'd1);
        tbl[5]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h38600005, 1'b0, 1'b0, 32'h0,        32'h7C000378, 1'b0, 16'd1);
        tbl[6]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h04000000, 32'h38600005, 1'b0, 16'd1);
        tbl[7]  = mk(1'b1, 32'h04000001, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h04000000, 32'h38600005, 1'b0, 16'd1);
        tbl[8]  = mk(1'b1, 32'h04000002, 1'b1, 1'b1, 1'b1, 32'h04000001, 1'b0, 1'b1, 32'h04000000, 32'h38600005, 1'b0, 16'd2);
        tbl[9]  = mk(1'b1, 32'h60000000, 1'b1, 1'b1, 1'b1, 32'h04000002, 1'b0, 1'b1, 32'h04000000, 32'h38600005, 1'b1, 16'd2);
        tbl[10] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h60000000, 1'b0, 1'b1, 32'h04000000, 32'h38600005, 1'b0, 16'd2);
        tbl[11] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h04000002, 32'h60000000, 1'b0, 16'd2);
        tbl[12] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h04000002, 32'h60000000, 1'b0, 16'd3);

        // Reset state
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", snap(), {11'b0, 1'b1, 116'b0});
        next_cycle();

        // Plain, prefixed and double-prefix sequences
        for (int i = 0; i < 13; i++) begin
            bus.fetch_valid = tbl[i].fv;
            bus.fetch_instr = tbl[i].instr;
            bus.issue_ready = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d", i), snap(), expect_of(tbl[i]));
            next_cycle();
        end

        // Backpressure: one word held for issue plus four buffered fills the FIFO
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bp_words[i]     = 32'h38600010 + 32'(i);
            bus.fetch_valid = 1'b1;
            bus.fetch_instr = bp_words[i];
            @(negedge clk);
            check($sformatf("bp_ready%0d", i), 128'(bus.fetch_ready), 128'(1'b1));
            next_cycle();
        end
        bus.fetch_valid = 1'b0;
        @(negedge clk);
        check("bp_full", 128'({bus.fetch_ready, bus.issue_valid, 32'(bus.issue_suffix)}),
              128'({1'b0, 1'b1, bp_words[0]}));
        next_cycle();
        bus.issue_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_issue%0d", i),
                  128'({bus.issue_valid, bus.issue_prefixed, 32'(bus.issue_suffix)}),
                  128'({1'b1, 1'b0, bp_words[i]}));
            next_cycle();
        end
        @(negedge clk);
        check("bp_count", 128'({bus.issue_valid, 16'(bus.issued_count)}), 128'({1'b0, 16'd8}));
        next_cycle();

        // Flush while a prefix is held
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = 32'h04000010;
        next_cycle();
        bus.fetch_valid = 1'b0;
        @(negedge clk);
        check("fl_prefix_pop", 128'(bus.id_en), 128'(1'b1));
        next_cycle();
        bus.flush       = 1'b1;
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = 32'h38600001;
        @(negedge clk);
        check("fl_cycle", 128'({bus.fetch_ready, bus.id_en}), 128'(2'b00));
        next_cycle();
        bus.flush       = 1'b0;
        bus.fetch_valid = 1'b0;
        @(negedge clk);
        check("fl_after", 128'({bus.issue_valid, bus.id_en, bus.fetch_ready}), 128'(3'b001));
        next_cycle();
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = 32'h38600002;
        next_cycle();
        bus.fetch_valid = 1'b0;
        wait_valid("fl_plain_wait");
        check("fl_plain", 128'({bus.issue_prefixed, 32'(bus.issue_prefix), 32'(bus.issue_suffix)}),
              128'({1'b0, 32'h0, 32'h38600002}));
        next_cycle();

        // Flush cancels a pending issue handshake
        bus.issue_ready = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = 32'h38600003;
        next_cycle();
        bus.fetch_valid = 1'b0;
        wait_valid("fl_hs_wait");
        next_cycle();
        bus.issue_ready = 1'b1;
        bus.flush       = 1'b1;
        next_cycle();
        bus.flush       = 1'b0;
        bus.issue_ready = 1'b0;
        @(negedge clk);
        check("fl_hs", 128'({bus.issue_valid, 16'(bus.issued_count)}), 128'({1'b0, 16'd9}));
        next_cycle();

        // Asynchronous reset while holding an instruction
        bus.fetch_valid = 1'b1;
        bus.fetch_instr = 32'h38600004;
        next_cycle();
        bus.fetch_valid = 1'b0;
        wait_valid("rst_wait");
        check("rst_pre_count", 128'(bus.issued_count), 128'(16'd9));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid", snap(), {11'b0, 1'b1, 116'b0});
        next_cycle();
        rst = 1'b0;

        // Random traffic against the stream model
        pend_valid = 1'b0;
        pend_word  = '0;
        err_exp    = 0;
        err_seen   = 0;
        model_cnt  = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 9) < 3) w[31:26] = 6'b000001;
            bus.fetch_valid = ($urandom_range(0, 9) < 7);
            bus.fetch_instr = w;
            bus.issue_ready = ($urandom_range(0, 3) != 0);
            sample_and_model();
        end
        bus.fetch_valid = 1'b0;
        bus.issue_ready = 1'b1;
        for (int c = 0; c < 40 && (q.size() != 0 || bus.issue_valid); c++) begin
            sample_and_model();
        end
        check("rnd_drained", 128'(q.size()), 128'(0));
        check("rnd_err_count", 128'(err_seen), 128'(err_exp));
        check("rnd_issued_count", 128'(bus.issued_count), 128'(16'(model_cnt)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
